// File: rtl/uart_pkg.sv
// Shared encodings for the UART loopback BIST: pattern modes, FSM states and
// the maximal-length LFSR tap table for payload widths 5..9.
package uart_pkg;

  typedef enum logic [1:0] {
    MODE_FIXED = 2'd0,
    MODE_INCR  = 2'd1,
    MODE_LFSR  = 2'd2
  } mode_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SEND    = 3'd2,
    WAIT_RX = 3'd3,
    CHECK   = 3'd4,
    FINISH  = 3'd5
  } state_e;

  // Fibonacci feedback masks (bit i set = stage i+1 tapped), shift-left form.
  function automatic logic [8:0] lfsr_taps(input int width);
    case (width)
      5:       return 9'h014;
      6:       return 9'h030;
      7:       return 9'h060;
      8:       return 9'h0B8;
      default: return 9'h110;
    endcase
  endfunction

endpackage

// File: rtl/bist_pattern_gen.sv
// Test-pattern source: reloads the seed on load, advances one step on step
// (hold, increment modulo 2^DATA_W, or maximal-length Fibonacci LFSR).
module bist_pattern_gen
  import uart_pkg::*;
#(
  parameter int    DATA_W = 8,
  parameter mode_e MODE   = MODE_INCR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] seed,
  output logic [DATA_W-1:0] pattern
);

  localparam logic [DATA_W-1:0] TAPS = DATA_W'(lfsr_taps(DATA_W));

  logic [DATA_W-1:0] pat_q, pat_d, seed_eff;

  always_comb begin
    seed_eff = seed;
    // An all-zero LFSR state never leaves zero, so substitute 1.
    if ((MODE == MODE_LFSR) && (seed == '0)) seed_eff = DATA_W'(1);
    pat_d = pat_q;
    if (load) begin
      pat_d = seed_eff;
    end else if (step) begin
      case (MODE)
        MODE_INCR: pat_d = pat_q + DATA_W'(1);
        MODE_LFSR: pat_d = {pat_q[DATA_W-2:0], ^(pat_q & TAPS)};
        default:   pat_d = pat_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pat_q <= '0;
    else      pat_q <= pat_d;
  end

  assign pattern = pat_q;

endmodule

// File: rtl/uart_loopback_bist.sv
// Loopback BIST controller: launches frames into an external uart_tx, checks
// what uart_rx returns, and counts mismatches, timeouts and stray frames.
module uart_loopback_bist
  import uart_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                NUM_FRAMES  = 16,
  parameter mode_e             MODE        = MODE_INCR,
  parameter logic [DATA_W-1:0] SEED        = DATA_W'(8'hC1),
  parameter int                TIMEOUT_CYC = 120000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_busy,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_done,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [15:0]       frame_count
);

  localparam logic [23:0] TMO_LAST   = 24'(TIMEOUT_CYC - 1);
  localparam logic [15:0] FRAMES_END = 16'(NUM_FRAMES);

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, a} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  state_e            state_q, state_d;
  logic              tx_start_q, tx_start_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [15:0]       err_q, err_d, frame_q, frame_d, frame_inc;
  logic [23:0]       tmo_q, tmo_d;
  logic [DATA_W-1:0] rx_cap_q, rx_cap_d, pattern;
  logic              pat_load, pat_step, clear_run, frame_end, frame_err, stray;

  bist_pattern_gen #(.DATA_W(DATA_W), .MODE(MODE)) u_pattern (
    .clk     (clk),
    .rst     (rst),
    .load    (pat_load),
    .step    (pat_step),
    .seed    (SEED),
    .pattern (pattern)
  );

  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    err_d      = err_q;
    frame_d    = frame_q;
    tmo_d      = tmo_q;
    rx_cap_d   = rx_cap_q;
    pat_load   = 1'b0;
    pat_step   = 1'b0;
    clear_run  = 1'b0;
    frame_end  = 1'b0;
    frame_err  = 1'b0;
    frame_inc  = frame_q + 16'd1;
    stray      = rx_done && busy_q && (state_q != WAIT_RX);

    case (state_q)
      IDLE: if (start) begin
        state_d   = LOAD;
        busy_d    = 1'b1;
        pass_d    = 1'b0;
        frame_d   = '0;
        clear_run = 1'b1;
        pat_load  = 1'b1;
      end
      LOAD: if (!tx_busy) begin
        tx_data_d  = pattern;
        tx_start_d = 1'b1;
        state_d    = SEND;
      end
      SEND: begin
        tmo_d   = '0;
        state_d = WAIT_RX;
      end
      WAIT_RX: begin
        // A reception in the expiry cycle still counts as a good frame.
        if (rx_done) begin
          rx_cap_d = rx_data;
          state_d  = CHECK;
        end else if (tmo_q == TMO_LAST) begin
          frame_end = 1'b1;
          frame_err = 1'b1;
        end else begin
          tmo_d = tmo_q + 24'd1;
        end
      end
      CHECK: begin
        frame_end = 1'b1;
        frame_err = (rx_cap_q != tx_data_q);
      end
      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (frame_end) begin
      frame_d = frame_inc;
      if (frame_inc == FRAMES_END) begin
        state_d = FINISH;
      end else begin
        pat_step = 1'b1;
        state_d  = LOAD;
      end
    end

    if (clear_run) err_d = '0;
    else           err_d = sat_add(err_q, {1'b0, frame_err} + {1'b0, stray});

    if (state_q == FINISH) pass_d = (err_d == 16'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      frame_q    <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      frame_q    <= frame_d;
      tmo_q      <= tmo_d;
    end
  end

  // Capture register is only read in CHECK, so it needs no reset.
  always_ff @(posedge clk) begin
    rx_cap_q <= rx_cap_d;
  end

  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_count   = err_q;
  assign frame_count = frame_q;

endmodule

// File: tb/tb_uart_loopback_bist.sv
// Scoreboard bench: four BIST instances with a behavioural UART loopback.
module tb_uart_loopback_bist;
  import uart_pkg::*;

  localparam int TO_CYC = 100;

  typedef struct {
    logic pass;
    int   err;
    int   fc;
  } run_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [3:0]       start_w, tx_start_w, tx_busy_w, rx_done_w, mdl_done, stray_w;
  logic [3:0]       busy_w, done_w, pass_w, mute, corrupt;
  logic [3:0][8:0]  txd, rxd;
  logic [3:0][15:0] err_w, fc_w;
  logic             tmo_chk;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_tx  [4][$];
  run_t exp_run [4][$];
  bit   seen [128];
  int   lfsr_n = 0;

  assign rx_done_w  = mdl_done | stray_w;
  assign txd[0][8]   = 1'b0;
  assign txd[1][8]   = 1'b0;
  assign txd[2][8]   = 1'b0;
  assign txd[3][8:7] = 2'b00;

  uart_loopback_bist #(.DATA_W(8), .NUM_FRAMES(4), .MODE(MODE_INCR), .SEED(8'hFE), .TIMEOUT_CYC(TO_CYC)) u0 (
    .clk(clk), .rst(rst_n), .start(start_w[0]), .tx_start(tx_start_w[0]), .tx_data(txd[0][7:0]),
    .tx_busy(tx_busy_w[0]), .rx_data(rxd[0][7:0]), .rx_done(rx_done_w[0]), .busy(busy_w[0]),
    .done(done_w[0]), .pass(pass_w[0]), .err_count(err_w[0]), .frame_count(fc_w[0]));

  uart_loopback_bist #(.DATA_W(8), .NUM_FRAMES(3), .MODE(MODE_FIXED), .SEED(8'hC1), .TIMEOUT_CYC(TO_CYC)) u1 (
    .clk(clk), .rst(rst_n), .start(start_w[1]), .tx_start(tx_start_w[1]), .tx_data(txd[1][7:0]),
    .tx_busy(tx_busy_w[1]), .rx_data(rxd[1][7:0]), .rx_done(rx_done_w[1]), .busy(busy_w[1]),
    .done(done_w[1]), .pass(pass_w[1]), .err_count(err_w[1]), .frame_count(fc_w[1]));

  uart_loopback_bist #(.DATA_W(8), .NUM_FRAMES(2), .MODE(MODE_INCR), .SEED(8'hC1), .TIMEOUT_CYC(TO_CYC)) u2 (
    .clk(clk), .rst(rst_n), .start(start_w[2]), .tx_start(tx_start_w[2]), .tx_data(txd[2][7:0]),
    .tx_busy(tx_busy_w[2]), .rx_data(rxd[2][7:0]), .rx_done(rx_done_w[2]), .busy(busy_w[2]),
    .done(done_w[2]), .pass(pass_w[2]), .err_count(err_w[2]), .frame_count(fc_w[2]));

  uart_loopback_bist #(.DATA_W(7), .NUM_FRAMES(127), .MODE(MODE_LFSR), .SEED(7'h00), .TIMEOUT_CYC(TO_CYC)) u3 (
    .clk(clk), .rst(rst_n), .start(start_w[3]), .tx_start(tx_start_w[3]), .tx_data(txd[3][6:0]),
    .tx_busy(tx_busy_w[3]), .rx_data(rxd[3][6:0]), .rx_done(rx_done_w[3]), .busy(busy_w[3]),
    .done(done_w[3]), .pass(pass_w[3]), .err_count(err_w[3]), .frame_count(fc_w[3]));

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  // UART loopback: a launched frame occupies the line for a random time,
  // then comes back (possibly muted or with bit 0 forced low).
  initial begin
    int       fly [4];
    logic [8:0] fly_d [4];
    tx_busy_w = '0;
    mdl_done  = '0;
    rxd       = '0;
    for (int k = 0; k < 4; k++) begin fly[k] = 0; fly_d[k] = '0; end
    forever begin
      @(negedge clk);
      mdl_done = '0;
      for (int k = 0; k < 4; k++) begin
        if (fly[k] > 0) begin
          fly[k]--;
          if (fly[k] == 0) begin
            tx_busy_w[k] = 1'b0;
            if (!mute[k]) begin
              mdl_done[k] = 1'b1;
              rxd[k]      = corrupt[k] ? (fly_d[k] & 9'h1FE) : fly_d[k];
            end
          end
        end else if (tx_start_w[k]) begin
          fly_d[k]     = txd[k];
          fly[k]       = $urandom_range(25, 3);
          tx_busy_w[k] = 1'b1;
        end
      end
    end
  end

  // Monitor: pops expectations whenever a DUT presents tx_start or done.
  initial begin
    int   cyc;
    int   v;
    int   last_txs [4];
    logic [15:0] prev_fc [4];
    run_t r;
    cyc = 0;
    for (int k = 0; k < 4; k++) begin last_txs[k] = 0; prev_fc[k] = '0; end
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      for (int k = 0; k < 4; k++) begin
        if (tx_start_w[k]) begin
          last_txs[k] = cyc;
          if (k == 3) begin
            v = int'(txd[3][6:0]);
            if (lfsr_n == 0) check("u3.lfsr_first", v, 1);
            check("u3.lfsr_nonzero", v != 0, 1);
            check("u3.lfsr_distinct", seen[v], 0);
            seen[v] = 1'b1;
            lfsr_n++;
          end else begin
            check($sformatf("u%0d.tx_expected", k), exp_tx[k].size() > 0, 1);
            if (exp_tx[k].size() > 0)
              check($sformatf("u%0d.tx_data", k), txd[k], exp_tx[k].pop_front());
          end
        end
        // fc is a register, so it shows the expiry decision one edge later.
        if (k == 2 && tmo_chk && fc_w[2] != prev_fc[2] && fc_w[2] != 16'd0)
          check("u2.timeout_cycles", cyc - last_txs[2], TO_CYC + 1);
        prev_fc[k] = fc_w[k];
        if (done_w[k]) begin
          check($sformatf("u%0d.done_expected", k), exp_run[k].size() > 0, 1);
          if (exp_run[k].size() > 0) begin
            r = exp_run[k].pop_front();
            check($sformatf("u%0d.pass", k), pass_w[k], r.pass);
            check($sformatf("u%0d.err_count", k), err_w[k], r.err);
            check($sformatf("u%0d.frame_count", k), fc_w[k], r.fc);
            check($sformatf("u%0d.busy_at_done", k), busy_w[k], 0);
          end
        end
      end
    end
  end

  task automatic start_run(input int k, input mode_e mode, input int seed, input int nf,
                           input int w, input int n_stray);
    int   errs;
    int   pat;
    run_t r;
    errs = n_stray;
    for (int i = 0; i < nf; i++) begin
      pat = (mode == MODE_FIXED) ? seed : (seed + i) % (1 << w);
      if (mode != MODE_LFSR) exp_tx[k].push_back(pat);
      if (mute[k]) errs++;
      else if (corrupt[k] && mode != MODE_LFSR && (pat % 2) == 1) errs++;
    end
    r.pass = (errs == 0);
    r.err  = errs;
    r.fc   = nf;
    exp_run[k].push_back(r);
    start_w[k] = 1'b1;
    @(negedge clk);
    start_w[k] = 1'b0;
    if (n_stray > 0) begin
      stray_w[k] = 1'b1;
      @(negedge clk);
      stray_w[k] = 1'b0;
    end
  endtask

  task automatic wait_run(input int k, input int budget);
    int n;
    n = 0;
    while (exp_run[k].size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("u%0d.done_in_budget", k), n < budget, 1);
    if (exp_run[k].size() != 0) begin
      exp_run[k].delete();
      exp_tx[k].delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    rst_n   = 1'b1;
    start_w = '0;
    stray_w = '0;
    mute    = '0;
    corrupt = '0;
    tmo_chk = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("u%0d.rst_busy", k), busy_w[k], 0);
      check($sformatf("u%0d.rst_err", k), err_w[k], 0);
      check($sformatf("u%0d.rst_fc", k), fc_w[k], 0);
    end
    check("u0.rst_tx_start", tx_start_w[0], 0);
    check("u0.rst_tx_data", txd[0], 0);
    check("u0.rst_done", done_w[0], 0);
    check("u0.rst_pass", pass_w[0], 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean incrementing run across the wrap, with an ignored start mid-run.
    start_run(0, MODE_INCR, 'hFE, 4, 8, 0);
    repeat (10) @(negedge clk);
    start_w[0] = 1'b1;
    @(negedge clk);
    start_w[0] = 1'b0;
    wait_run(0, 1000);

    // Fixed pattern with bit 0 forced low on the receive side.
    corrupt[1] = 1'b1;
    start_run(1, MODE_FIXED, 'hC1, 3, 8, 0);
    wait_run(1, 1000);
    corrupt[1] = 1'b0;
    stray_w[1] = 1'b1;
    @(negedge clk);
    stray_w[1] = 1'b0;
    repeat (5) @(negedge clk);
    check("u1.idle_rx_ignored_err", err_w[1], 3);
    check("u1.pass_held", pass_w[1], 0);
    check("u1.fc_held", fc_w[1], 3);

    // Receiver silent: every frame expires.
    mute[2]  = 1'b1;
    tmo_chk  = 1'b1;
    start_run(2, MODE_INCR, 'hC1, 2, 8, 0);
    wait_run(2, 1000);
    mute[2]  = 1'b0;
    tmo_chk  = 1'b0;

    // Stray reception while the first frame is still being loaded.
    start_run(2, MODE_INCR, 'hC1, 2, 8, 1);
    wait_run(2, 1000);

    // Reset in WAIT_RX of frame 2, then a fresh clean run.
    start_run(0, MODE_INCR, 'hFE, 4, 8, 0);
    n = 0;
    while (fc_w[0] != 16'd1 && n < 300) begin @(negedge clk); n++; end
    check("u0.reach_frame2", n < 300, 1);
    n = 0;
    while (!tx_start_w[0] && n < 300) begin @(negedge clk); n++; end
    check("u0.frame2_launch", n < 300, 1);
    @(negedge clk);
    exp_run[0].delete();
    exp_tx[0].delete();
    rst_n = 1'b0;
    #1;
    check("u0.abort_busy", busy_w[0], 0);
    check("u0.abort_tx_start", tx_start_w[0], 0);
    check("u0.abort_tx_data", txd[0], 0);
    check("u0.abort_done", done_w[0], 0);
    check("u0.abort_pass", pass_w[0], 0);
    check("u0.abort_err", err_w[0], 0);
    check("u0.abort_fc", fc_w[0], 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("u0.post_reset_err", err_w[0], 0);
    start_run(0, MODE_INCR, 'hFE, 4, 8, 0);
    wait_run(0, 1000);

    // LFSR sequence over a full period.
    start_run(3, MODE_LFSR, 0, 127, 7, 0);
    wait_run(3, 8000);
    check("u3.lfsr_frames", lfsr_n, 127);

    for (int k = 0; k < 3; k++)
      check($sformatf("u%0d.tx_left", k), exp_tx[k].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
